// File: rtl/ser_word_loader_pkg.sv
// Shared definitions for the serial word loader: FSM state encodings and default sizing.
package ser_word_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  localparam int N_DEFAULT  = 4;
  localparam int CW_DEFAULT = 3;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for the serial loader: async clear, sync clear, increment, done at count == n.
module ser_bit_counter
  import ser_word_loader_pkg::*;
#(
  parameter int n  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sclr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (sclr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == CW'(n));

endmodule

// File: rtl/ser_word_loader.sv
// Serial-to-parallel loader: assembles an LSB-first bit stream into an n-bit word and
// hands it to the downstream register with a one-cycle load strobe.
module ser_word_loader
  import ser_word_loader_pkg::*;
#(
  parameter int n  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         serIn,
  input  logic         serValid,
  output logic         serReady,
  input  logic         ldEn,
  input  logic         flush,
  output logic [n-1:0] wordOut,
  output logic         ldSt,
  output logic         busy
);

  state_t        state_q;
  state_t        state_d;
  logic [n-1:0]  sr_q;
  logic [n-1:0]  sr_d;
  logic [CW-1:0] count;
  logic          done;
  logic          xfer;
  logic          last_bit;

  // New bit enters at the top so the first accepted bit drifts down to bit 0.
  function automatic logic [n-1:0] shift_in(input logic [n-1:0] sr, input logic b);
    logic [n-1:0] r;
    for (int i = 0; i < n - 1; i++) begin
      r[i] = sr[i+1];
    end
    r[n-1] = b;
    return r;
  endfunction

  assign xfer     = serValid && serReady;
  assign last_bit = (count == CW'(n - 1));

  ser_bit_counter #(
    .n  (n),
    .CW (CW)
  ) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .sclr  (flush || (state_q == ST_LOAD)),
    .inc   (xfer),
    .count (count),
    .done  (done)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  // IDLE and SHIFT behave alike: count is 0 in IDLE, so n == 1 goes straight to FULL.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHIFT: if (xfer) state_d = last_bit ? ST_FULL : ST_SHIFT;
        ST_FULL:           if (ldEn && done) state_d = ST_LOAD;
        ST_LOAD:           state_d = ST_IDLE;
        default:           state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (flush) begin
      sr_d = '0;
    end else if (xfer) begin
      sr_d = shift_in(sr_q, serIn);
    end
  end

  always_comb begin
    serReady = (state_q == ST_IDLE) || (state_q == ST_SHIFT);
    ldSt     = (state_q == ST_LOAD);
    busy     = (state_q != ST_IDLE);
  end

  assign wordOut = sr_q;

endmodule

// File: tb/tb_ser_word_loader.sv
// Self-checking bench for ser_word_loader: directed scenarios plus a randomized run
// against a queue-based model of the word assembly and handshake.
module tb_ser_word_loader;

  localparam int N  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         clr;
  logic         serIn;
  logic         serValid;
  logic         serReady;
  logic         ldEn;
  logic         flush;
  logic [N-1:0] wordOut;
  logic         ldSt;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Model: bits collected for the current word, word-complete flag, load-cycle flag.
  bit           m_q[$];
  bit           m_pend;
  bit           m_load;
  logic [N-1:0] dut_reg;

  always #5 clk = ~clk;

  ser_word_loader #(
    .n  (N),
    .CW (CW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .serIn    (serIn),
    .serValid (serValid),
    .serReady (serReady),
    .ldEn     (ldEn),
    .flush    (flush),
    .wordOut  (wordOut),
    .ldSt     (ldSt),
    .busy     (busy)
  );

  // Downstream register stand-in: captures wordOut on the edge that ends the strobe cycle.
  always @(posedge clk) if (ldSt) dut_reg <= wordOut;

  function automatic logic [N-1:0] qword();
    logic [N-1:0] w = '0;
    for (int i = 0; i < m_q.size() && i < N; i++) w[i] = m_q[i];
    return w;
  endfunction

  // {serReady, busy, ldSt}
  function automatic logic [2:0] exp_flags();
    return {!m_pend && !m_load, (m_q.size() > 0) || m_pend || m_load, m_load};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pend = 0;
    m_load = 0;
  endtask

  task automatic cyc(input bit v, input bit b, input bit en, input bit fl);
    serValid = v;
    serIn    = b;
    ldEn     = en;
    flush    = fl;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else if (m_load) begin
      model_clear();
    end else if (m_pend) begin
      if (en) begin
        m_load = 1;
        m_pend = 0;
      end
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() == N) m_pend = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    serValid = 0; serIn = 0; ldEn = 0; flush = 0;
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({serReady, busy, ldSt} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=100", {serReady, busy, ldSt});
    end
    checks++;
    if (wordOut !== '0) begin
      errors++;
      $display("FAIL reset_word got=%h exp=0", wordOut);
    end
  endtask

  task automatic test_basic();
    bit bits[4] = '{1, 0, 1, 1};
    for (int i = 0; i < 4; i++) cyc(1, bits[i], 1, 0);
    checks++;
    if ({serReady, busy, ldSt} !== 3'b010) begin
      errors++;
      $display("FAIL basic_full got=%b exp=010", {serReady, busy, ldSt});
    end
    cyc(0, 0, 1, 0);
    checks++;
    if ({serReady, busy, ldSt, wordOut} !== {3'b011, 4'hD}) begin
      errors++;
      $display("FAIL basic_load got=%b/%h exp=011/d", {serReady, busy, ldSt}, wordOut);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if ({serReady, busy, ldSt} !== 3'b100) begin
      errors++;
      $display("FAIL basic_idle got=%b exp=100", {serReady, busy, ldSt});
    end
    checks++;
    if (dut_reg !== 4'hD || wordOut !== 4'hD) begin
      errors++;
      $display("FAIL basic_reg got reg=%h word=%h exp=d", dut_reg, wordOut);
    end
  endtask

  task automatic test_gapped();
    bit bits[4] = '{1, 0, 1, 1};
    int pulses = 0;
    logic [N-1:0] w = '0;
    for (int s = 0; s < 16; s++) begin
      if (s < 12 && s % 3 == 0) cyc(1, bits[s/3], 1, 0);
      else cyc(0, 0, 1, 0);
      if (ldSt) begin
        pulses++;
        w = wordOut;
      end
    end
    checks++;
    if (pulses != 1 || w !== 4'hD) begin
      errors++;
      $display("FAIL gapped got pulses=%0d word=%h exp pulses=1 word=d", pulses, w);
    end
  endtask

  task automatic test_stall();
    bit bits[4] = '{0, 1, 1, 0};
    bit rb;
    for (int i = 0; i < 4; i++) cyc(1, bits[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      rb = 1'($urandom);
      cyc(1, rb, 0, 0);
      checks++;
      if ({serReady, busy, ldSt, wordOut} !== {3'b010, 4'h6}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h exp=010/6", i, {serReady, busy, ldSt}, wordOut);
      end
    end
    cyc(1, 1, 1, 0);
    checks++;
    if ({ldSt, wordOut} !== {1'b1, 4'h6}) begin
      errors++;
      $display("FAIL stall_release got ldSt=%b word=%h exp 1/6", ldSt, wordOut);
    end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_flush();
    bit bits[4] = '{0, 0, 1, 0};
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 1);
    checks++;
    if ({serReady, busy, ldSt, wordOut} !== {3'b100, 4'h0}) begin
      errors++;
      $display("FAIL flush_idle got=%b/%h exp=100/0", {serReady, busy, ldSt}, wordOut);
    end
    for (int i = 0; i < 4; i++) cyc(1, bits[i], 1, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if ({ldSt, wordOut} !== {1'b1, 4'h4}) begin
      errors++;
      $display("FAIL flush_word got ldSt=%b word=%h exp 1/4", ldSt, wordOut);
    end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if ({serReady, busy, ldSt, wordOut} !== {3'b100, {N{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset got=%b/%h exp=100/0", {serReady, busy, ldSt}, wordOut);
    end
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if ({ldSt, wordOut} !== {1'b1, 4'hF}) begin
      errors++;
      $display("FAIL async_fresh got ldSt=%b word=%h exp 1/f", ldSt, wordOut);
    end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    bit bits[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    logic [N-1:0] exp_w[2] = '{4'hA, 4'h5};
    int idx = 0;
    int pulses = 0;
    int t[2] = '{0, 0};
    int low_run = 0;
    int first_gap = -1;
    bit acc;
    for (int c = 0; c < 30 && pulses < 2; c++) begin
      acc = exp_flags()[2] && (idx < 8);
      cyc(idx < 8, (idx < 8) ? bits[idx] : 1'b0, 1, 0);
      if (acc) idx++;
      if (!serReady) low_run++;
      else begin
        if (low_run > 0 && first_gap < 0) first_gap = low_run;
        low_run = 0;
      end
      if (ldSt) begin
        checks++;
        if (wordOut !== exp_w[pulses]) begin
          errors++;
          $display("FAIL b2b_word%0d got=%h exp=%h", pulses, wordOut, exp_w[pulses]);
        end
        t[pulses] = c;
        pulses++;
      end
    end
    checks++;
    if (pulses < 2) begin
      errors++;
      $display("FAIL b2b_timeout got pulses=%0d exp=2", pulses);
    end else if (t[1] - t[0] != N + 2) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", t[1] - t[0], N + 2);
    end
    checks++;
    if (first_gap != 2) begin
      errors++;
      $display("FAIL b2b_ready_gap got=%0d exp=2", first_gap);
    end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit v, b, en, fl;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      en = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 29) == 0);
      cyc(v, b, en, fl);
      checks++;
      if ({serReady, busy, ldSt} !== exp_flags()) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d got=%b exp=%b", c, {serReady, busy, ldSt}, exp_flags());
      end
      if (m_load) begin
        checks++;
        if (wordOut !== qword()) begin
          errors++;
          $display("FAIL rand_word cyc=%0d got=%h exp=%h", c, wordOut, qword());
        end
      end
    end
  endtask

  initial begin
    clr = 1'b1; serValid = 0; serIn = 0; ldEn = 0; flush = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
